// File: rtl/debounce_entrada_pkg.sv
// Shared types and constants for the input conditioning block.
package debounce_entrada_pkg;

  typedef enum logic [1:0] {
    SOLTO          = 2'd0,
    CONFIRMA_PRESS = 2'd1,
    PRESSIONADO    = 2'd2,
    CONFIRMA_SOLTA = 2'd3
  } estado_t;

  localparam int DATA_W_DEF          = 18;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int SYNC_STAGES_DEF     = 2;

  // Counter wide enough to hold 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_entrada_sincronizador.sv
// Multi-flop synchroniser for asynchronous inputs, reset to a chosen idle level.
module sincronizador #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] etapa [STAGES];

  // Shift chain; the first stage may go metastable, later stages resolve it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) etapa[i] <= RESET_VAL;
    end else begin
      etapa[0] <= d;
      for (int i = 1; i < STAGES; i++) etapa[i] <= etapa[i-1];
    end
  end

  assign q = etapa[STAGES-1];

endmodule

// File: rtl/debounce_entrada.sv
// Synchronises the board switches and button, debounces the button and
// captures the switch word at each confirmed press.
//
//   state          | meaning
//   SOLTO          | button released and stable
//   CONFIRMA_PRESS | button seen pressed, waiting for it to stay pressed
//   PRESSIONADO    | button pressed and stable, switch word captured
//   CONFIRMA_SOLTA | button seen released, waiting for it to stay released
module debounce_entrada
  import debounce_entrada_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit BTN_ATIVO_BAIXO = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] switch_in,
  input  logic              btn_in,
  output logic [DATA_W-1:0] switch_out,
  output logic              btn_out,
  output logic              btn_pulso,
  output logic              estavel
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] switch_sync;
  logic [0:0]        btn_raw_sync;
  logic              btn_sync;

  estado_t           state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-1:0] switch_next;
  logic              btn_out_next, btn_pulso_next, estavel_next;

  sincronizador #(
    .WIDTH    (DATA_W),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL({DATA_W{1'b0}})
  ) u_sync_switch (
    .clock(clock),
    .reset(reset),
    .d    (switch_in),
    .q    (switch_sync)
  );

  // Button synchroniser idles at the raw released level so reset never looks like a press.
  sincronizador #(
    .WIDTH    (1),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'(BTN_ATIVO_BAIXO))
  ) u_sync_btn (
    .clock(clock),
    .reset(reset),
    .d    (btn_in),
    .q    (btn_raw_sync)
  );

  assign btn_sync = btn_raw_sync[0] ^ 1'(BTN_ATIVO_BAIXO);

  // State, stability counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= SOLTO;
      cnt        <= '0;
      switch_out <= '0;
      btn_out    <= 1'b0;
      btn_pulso  <= 1'b0;
      estavel    <= 1'b1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      switch_out <= switch_next;
      btn_out    <= btn_out_next;
      btn_pulso  <= btn_pulso_next;
      estavel    <= estavel_next;
    end
  end

  // Next-state and next-output logic; counter restarts on every state change.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    switch_next    = switch_out;
    btn_out_next   = btn_out;
    btn_pulso_next = 1'b0;
    unique case (state)
      SOLTO: begin
        if (btn_sync) begin
          state_next = CONFIRMA_PRESS;
          cnt_next   = '0;
        end
      end
      CONFIRMA_PRESS: begin
        if (!btn_sync) begin
          state_next = SOLTO;
          cnt_next   = '0;
        end else if (cnt == CNT_FIM) begin
          state_next     = PRESSIONADO;
          cnt_next       = '0;
          btn_out_next   = 1'b1;
          btn_pulso_next = 1'b1;
          switch_next    = switch_sync;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSIONADO: begin
        if (!btn_sync) begin
          state_next = CONFIRMA_SOLTA;
          cnt_next   = '0;
        end
      end
      CONFIRMA_SOLTA: begin
        if (btn_sync) begin
          state_next = PRESSIONADO;
          cnt_next   = '0;
        end else if (cnt == CNT_FIM) begin
          state_next   = SOLTO;
          cnt_next     = '0;
          btn_out_next = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = SOLTO;
        cnt_next   = '0;
      end
    endcase
    estavel_next = (state_next == SOLTO) || (state_next == PRESSIONADO);
  end

endmodule

// File: tb/tb_debounce_entrada.sv
// Directed bench for debounce_entrada with a short debounce window.
module tb_debounce_entrada;

  localparam int DATA_W = 18;

  typedef struct {
    logic              btn;
    logic [DATA_W-1:0] sw;
    logic              e_btn;
    logic              e_pulso;
    logic              e_est;
    logic [DATA_W-1:0] e_sw;
    string             nome;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] switch_in;
  logic              btn_in;
  logic [DATA_W-1:0] switch_out;
  logic              btn_out;
  logic              btn_pulso;
  logic              estavel;

  int checks = 0;
  int errors = 0;
  vec_t tab[$];

  debounce_entrada #(
    .DATA_W         (DATA_W),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .BTN_ATIVO_BAIXO(1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .switch_in (switch_in),
    .btn_in    (btn_in),
    .switch_out(switch_out),
    .btn_out   (btn_out),
    .btn_pulso (btn_pulso),
    .estavel   (estavel)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nome, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input string nome, input logic btn, input logic [DATA_W-1:0] sw,
                     input logic e_btn, input logic e_pulso, input logic e_est,
                     input logic [DATA_W-1:0] e_sw);
    vec_t v;
    v.nome = nome; v.btn = btn; v.sw = sw;
    v.e_btn = e_btn; v.e_pulso = e_pulso; v.e_est = e_est; v.e_sw = e_sw;
    tab.push_back(v);
  endtask

  task automatic chk_all(input string nome, input logic e_btn, input logic e_pulso,
                         input logic e_est, input logic [DATA_W-1:0] e_sw);
    chk({nome, ".btn_out"}, 32'(btn_out), 32'(e_btn));
    chk({nome, ".btn_pulso"}, 32'(btn_pulso), 32'(e_pulso));
    chk({nome, ".estavel"}, 32'(estavel), 32'(e_est));
    chk({nome, ".switch_out"}, 32'(switch_out), 32'(e_sw));
  endtask

  initial begin
    // Press A: latency 7, capture 2A5A5, unstable on edges 3-6.
    for (int k = 1; k <= 8; k++)
      add($sformatf("pressA_e%0d", k), 1'b0, 18'h2A5A5,
          k >= 7, k == 7, !(k >= 3 && k <= 6), (k >= 7) ? 18'h2A5A5 : 18'h0);
    // Switches move while held: ignored.
    for (int k = 1; k <= 2; k++)
      add($sformatf("holdsw_e%0d", k), 1'b0, 18'h00001, 1'b1, 1'b0, 1'b1, 18'h2A5A5);
    // Clean release: btn_out drops at edge 7, no pulse.
    for (int k = 1; k <= 8; k++)
      add($sformatf("rel_e%0d", k), 1'b1, 18'h00001,
          k < 7, 1'b0, !(k >= 3 && k <= 6), 18'h2A5A5);
    // Three-cycle glitch: rejected.
    for (int k = 1; k <= 7; k++)
      add($sformatf("glitch_e%0d", k), (k > 3), 18'h00001,
          1'b0, 1'b0, !(k >= 3 && k <= 5), 18'h2A5A5);
    // Press B captures the new switch word.
    for (int k = 1; k <= 8; k++)
      add($sformatf("pressB_e%0d", k), 1'b0, 18'h00001,
          k >= 7, k == 7, !(k >= 3 && k <= 6), (k >= 7) ? 18'h00001 : 18'h2A5A5);

    // Reset held with the button down and all switches up.
    reset = 1'b0; btn_in = 1'b0; switch_in = 18'h3FFFF;
    step(); step(); step();
    chk_all("reset", 1'b0, 1'b0, 1'b1, 18'h0);
    btn_in = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_all($sformatf("idle_e%0d", k), 1'b0, 1'b0, 1'b1, 18'h0);
    end

    foreach (tab[i]) begin
      btn_in = tab[i].btn;
      switch_in = tab[i].sw;
      step();
      chk_all(tab[i].nome, tab[i].e_btn, tab[i].e_pulso, tab[i].e_est, tab[i].e_sw);
    end

    // Bounced release: high 2, low 2, then high for good (before edge 5).
    for (int k = 1; k <= 11; k++) begin
      btn_in = !(k == 3 || k == 4);
      step();
      chk($sformatf("bounce_e%0d.btn_out", k), 32'(btn_out), 32'(k < 11));
      chk($sformatf("bounce_e%0d.btn_pulso", k), 32'(btn_pulso), 32'h0);
    end
    chk("bounce.switch_out", 32'(switch_out), 32'h00001);

    // Reset mid-confirmation with the button held.
    btn_in = 1'b1;
    step(); step();
    btn_in = 1'b0; switch_in = 18'h3FFFF;
    for (int k = 1; k <= 4; k++) step();
    chk_all("pre_rst", 1'b0, 1'b0, 1'b0, 18'h00001);
    #2 reset = 1'b0;
    #1 chk_all("async_rst", 1'b0, 1'b0, 1'b1, 18'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("repress_e%0d", k), k >= 7, k == 7, !(k >= 3 && k <= 6),
              (k >= 7) ? 18'h3FFFF : 18'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
